// File: rtl/countdown_ctrl.sv
// countdown_ctrl: mode/sequencing controller for the HH:MM countdown timer.
//
// Turns pre-debounced one-cycle button pulses and a 1 Hz tick into registered
// single-cycle strobes for the BCD digit-counter chain. It also drives the
// hour-ones wrap configuration and the alarm/blink display controls.
//
// Ports:
//   clk_out    in   system clock, rising edge
//   rst_n      in   synchronous reset, active high (1 = reset)
//   tick_1hz   in   one-cycle pulse once per second
//   btn_mode   in   one-cycle mode key pulse
//   btn_start  in   one-cycle start/pause key pulse
//   btn_inc    in   one-cycle increment key pulse
//   zero       in   all digit counters read 0
//   hour1_is2  in   hour tens digit equals 2
//   dec_pulse  out  one-cycle decrement to the minute-ones counter
//   inc_min    out  one-cycle increase_set to the minute-ones counter
//   inc_hour   out  one-cycle increase_set to the hour-ones counter
//   re_hour    out  re of the hour-ones counter (wrap 3->0 at hour 23)
//   state      out  current FSM state code
//   alarm      out  high while in DONE
//   blink      out  blink phase for the digit group being set
module countdown_ctrl #(
  parameter int unsigned ALARM_SECS = 10,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk_out,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_start,
  input  logic       btn_inc,
  input  logic       zero,
  input  logic       hour1_is2,
  output logic       dec_pulse,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       re_hour,
  output logic [2:0] state,
  output logic       alarm,
  output logic       blink
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSetHour = 3'd1,
    StSetMin  = 3'd2,
    StRun     = 3'd3,
    StPause   = 3'd4,
    StDone    = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] AlarmLast = CNT_W'(ALARM_SECS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dec_q, dec_d;
  logic               inc_min_q, inc_min_d;
  logic               inc_hour_q, inc_hour_d;
  logic               alarm_q, alarm_d;
  logic               blink_q, blink_d;
  logic               in_set_q, in_set_d;

  // State register.
  always_ff @(posedge clk_out) begin
    if (rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dec_q      <= 1'b0;
      inc_min_q  <= 1'b0;
      inc_hour_q <= 1'b0;
      alarm_q    <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dec_q      <= dec_d;
      inc_min_q  <= inc_min_d;
      inc_hour_q <= inc_hour_d;
      alarm_q    <= alarm_d;
      blink_q    <= blink_d;
    end
  end

  // Next-state and next strobe values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dec_d      = 1'b0;
    inc_min_d  = 1'b0;
    inc_hour_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (btn_mode) begin
          state_d = StSetHour;
        end else if (btn_start && !zero) begin
          state_d = StRun;
        end
      end
      StSetHour: begin
        // Mode wins over a same-cycle increment; the increment is dropped.
        if (btn_mode) begin
          state_d = StSetMin;
        end else if (btn_inc) begin
          inc_hour_d = 1'b1;
        end
      end
      StSetMin: begin
        if (btn_mode) begin
          state_d = StIdle;
        end else if (btn_inc) begin
          inc_min_d = 1'b1;
        end
      end
      StRun: begin
        if (btn_start) begin
          state_d = StPause;
        end else if (tick_1hz && !zero) begin
          dec_d = 1'b1;
        end else if (tick_1hz && zero) begin
          state_d = StDone;
          cnt_d   = '0;
        end
      end
      StPause: begin
        if (btn_mode) begin
          state_d = StIdle;
        end else if (btn_start) begin
          state_d = StRun;
        end
      end
      StDone: begin
        if (btn_mode || btn_start || btn_inc) begin
          state_d = StIdle;
        end else if (tick_1hz) begin
          if (cnt_q == AlarmLast) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    in_set_q = (state_q == StSetHour) || (state_q == StSetMin);
    in_set_d = (state_d == StSetHour) || (state_d == StSetMin);

    // Blink keeps toggling across the SET_HOUR -> SET_MIN hand-over; it is
    // cleared whenever the next state is outside the set group.
    blink_d = in_set_d ? (blink_q ^ (tick_1hz & in_set_q)) : 1'b0;

    alarm_d = (state_d == StDone);
  end

  // Outputs.
  always_comb begin
    re_hour   = hour1_is2 & (state_q == StSetHour);
    dec_pulse = dec_q;
    inc_min   = inc_min_q;
    inc_hour  = inc_hour_q;
    state     = state_q;
    alarm     = alarm_q;
    blink     = blink_q;
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
module tb_countdown_ctrl;

  localparam int unsigned ALARM_SECS = 10;
  localparam int unsigned CNT_W      = 4;

  logic       clk_out = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_inc = 1'b0;
  logic       zero = 1'b0;
  logic       hour1_is2 = 1'b0;
  logic       dec_pulse, inc_min, inc_hour, re_hour, alarm, blink;
  logic [2:0] state;

  countdown_ctrl #(
    .ALARM_SECS (ALARM_SECS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_out   (clk_out),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .btn_mode  (btn_mode),
    .btn_start (btn_start),
    .btn_inc   (btn_inc),
    .zero      (zero),
    .hour1_is2 (hour1_is2),
    .dec_pulse (dec_pulse),
    .inc_min   (inc_min),
    .inc_hour  (inc_hour),
    .re_hour   (re_hour),
    .state     (state),
    .alarm     (alarm),
    .blink     (blink)
  );

  always #5 clk_out = ~clk_out;

  int checks = 0;
  int errors = 0;

  // Reference model: mode as a plain integer, strobes as "what happens next".
  localparam int M_IDLE = 0, M_SETH = 1, M_SETM = 2, M_RUN = 3, M_PAUSE = 4, M_DONE = 5;
  int m_mode = M_IDLE;
  int m_done_ticks = 0;  // ticks seen since DONE was entered
  bit m_dec = 0, m_incm = 0, m_inch = 0, m_blink = 0;

  int n_dec = 0, n_incm = 0, n_inch = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_set(input int m);
    return (m == M_SETH) || (m == M_SETM);
  endfunction

  task automatic model_update(input bit r, input bit md, input bit st, input bit ic,
                              input bit tk, input bit z);
    int nxt;
    m_dec = 0; m_incm = 0; m_inch = 0;
    if (r) begin
      m_mode = M_IDLE; m_blink = 0; m_done_ticks = 0;
      return;
    end
    nxt = m_mode;
    case (m_mode)
      M_IDLE:  if (md) nxt = M_SETH; else if (st && !z) nxt = M_RUN;
      M_SETH:  if (md) nxt = M_SETM; else if (ic) m_inch = 1;
      M_SETM:  if (md) nxt = M_IDLE; else if (ic) m_incm = 1;
      M_RUN:   if (st) nxt = M_PAUSE;
               else if (tk && !z) m_dec = 1;
               else if (tk) begin nxt = M_DONE; m_done_ticks = 0; end
      M_PAUSE: if (md) nxt = M_IDLE; else if (st) nxt = M_RUN;
      M_DONE:  if (md || st || ic) nxt = M_IDLE;
               else if (tk) begin
                 m_done_ticks++;
                 if (m_done_ticks == ALARM_SECS) nxt = M_IDLE;
               end
      default: nxt = M_IDLE;
    endcase
    if (is_set(nxt)) m_blink = m_blink ^ (tk && is_set(m_mode));
    else m_blink = 0;
    m_mode = nxt;
  endtask

  // Apply one cycle of inputs (called at a negedge), then compare at the next negedge.
  task automatic step(input bit r, input bit md, input bit st, input bit ic, input bit tk);
    rst_n = r; btn_mode = md; btn_start = st; btn_inc = ic; tick_1hz = tk;
    @(posedge clk_out);
    model_update(r, md, st, ic, tk, zero);
    @(negedge clk_out);
    check_eq("state", 32'(state), 32'(m_mode));
    check_eq("dec_pulse", 32'(dec_pulse), 32'(m_dec));
    check_eq("inc_min", 32'(inc_min), 32'(m_incm));
    check_eq("inc_hour", 32'(inc_hour), 32'(m_inch));
    check_eq("alarm", 32'(alarm), 32'(m_mode == M_DONE));
    check_eq("blink", 32'(blink), 32'(m_blink));
    check_eq("re_hour", 32'(re_hour), 32'(hour1_is2 && (m_mode == M_SETH)));
    check_eq("one_strobe", 32'(int'(dec_pulse) + int'(inc_min) + int'(inc_hour) <= 1), 32'd1);
    n_dec += int'(dec_pulse); n_incm += int'(inc_min); n_inch += int'(inc_hour);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk_out);
    // Reset
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_eq("reset_state", 32'(state), 32'd0);

    // Set sequence
    n_inch = 0; n_incm = 0;
    step(0, 1, 0, 0, 0);
    check_eq("set_enter_hour", 32'(state), 32'd1);
    for (int i = 0; i < 3; i++) begin step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 1); end
    step(0, 1, 0, 0, 0);
    check_eq("set_enter_min", 32'(state), 32'd2);
    for (int i = 0; i < 2; i++) begin step(0, 0, 0, 1, 0); idle(1); end
    step(0, 1, 0, 0, 0);
    check_eq("set_back_idle", 32'(state), 32'd0);
    check_eq("inc_hour_count", 32'(n_inch), 32'd3);
    check_eq("inc_min_count", 32'(n_incm), 32'd2);

    // Hour wrap configuration
    hour1_is2 = 1;
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check_eq("wrap_re_with_inc", 32'({inc_hour, re_hour}), 32'h3);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check_eq("wrap_re_in_min", 32'({inc_min, re_hour}), 32'h2);
    step(0, 1, 0, 0, 0);
    hour1_is2 = 0;

    // Countdown to done
    zero = 0; n_dec = 0;
    step(0, 0, 1, 0, 0);
    check_eq("run_enter", 32'(state), 32'd3);
    for (int i = 0; i < 5; i++) begin step(0, 0, 0, 0, 1); idle(1); end
    check_eq("dec_count", 32'(n_dec), 32'd5);
    zero = 1;
    step(0, 0, 0, 0, 1);
    check_eq("done_enter", 32'({state, alarm, dec_pulse}), 32'({3'd5, 1'b1, 1'b0}));
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 1);
      if (i == 8) check_eq("done_hold_9", 32'(state), 32'd5);
    end
    check_eq("done_timeout", 32'({state, alarm}), 32'({3'd0, 1'b0}));

    // Reset mid-RUN with all inputs active
    zero = 0;
    step(0, 0, 1, 0, 0);
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1);
    check_eq("reset_mid_run",
             32'({state, dec_pulse, inc_min, inc_hour, alarm, blink}), 32'd0);

    // Pause priority
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    check_eq("pause_over_tick", 32'({state, dec_pulse}), 32'({3'd4, 1'b0}));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    check_eq("pause_hold", 32'(state), 32'd4);
    step(0, 0, 1, 0, 0);
    check_eq("pause_resume", 32'(state), 32'd3);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    check_eq("pause_mode_wins", 32'(state), 32'd0);

    // Guard cases
    zero = 1;
    step(0, 0, 1, 0, 0);
    check_eq("start_zero_ignored", 32'(state), 32'd0);
    zero = 0;
    step(0, 0, 1, 0, 0);
    zero = 1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    check_eq("done_button_exit", 32'({state, alarm}), 32'({3'd0, 1'b0}));
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    idle(1);
    check_eq("mode_inc_drop", 32'({state, inc_hour}), 32'({3'd2, 1'b0}));
    step(0, 1, 0, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) zero = ~zero;
      hour1_is2 = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
